// File: rtl/uart_caesar_decoder_if.sv
// Serial-side signal bundle of the Caesar UART decoder.
// The slave modport is the decoder's view; master is the board/bench side.
`timescale 1ns/1ps
interface uart_caesar_decoder_if;
    logic uart_rx;
    logic uart_cts_n;
    logic uart_tx;
    logic overflow;
    logic frame_err;

    modport master (
        output uart_rx,
        output uart_cts_n,
        input  uart_tx,
        input  overflow,
        input  frame_err
    );

    modport slave (
        input  uart_rx,
        input  uart_cts_n,
        output uart_tx,
        output overflow,
        output frame_err
    );
endinterface

// File: rtl/uart_caesar_decoder.sv
// 8N1 receiver -> Caesar decrypt -> byte FIFO -> CTS-gated 8N1 transmitter.
// Define UART_CAESAR_DEC_FRAME_CHECK_EN to drop frames with a low stop bit and pulse frame_err.
`timescale 1ns/1ps
module uart_caesar_decoder #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115_200,
    parameter int SHIFT    = 3,
    parameter int DEPTH    = 8
) (
    input  logic                  clk50,
    input  logic                  reset_n,
    uart_caesar_decoder_if.slave  bus
);
    localparam int BIT_CLKS  = CLK_FREQ / BAUD;
    localparam int HALF_CLKS = BIT_CLKS / 2;
    localparam int CW        = $clog2(BIT_CLKS);
    localparam int AW        = $clog2(DEPTH);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CLKS - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CLKS - 1);
    localparam logic [5:0]    ROT       = 6'(26 - SHIFT);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    // Rotating back by SHIFT is done as rotating forward by 26-SHIFT, so the sum stays non-negative.
    function automatic logic [7:0] caesar_decrypt(input logic [7:0] c);
        logic [7:0] base;
        logic [5:0] rot;
        logic       is_letter;
        base      = 8'h00;
        is_letter = 1'b0;
        if (c >= 8'h41 && c <= 8'h5A) begin
            base      = 8'h41;
            is_letter = 1'b1;
        end else if (c >= 8'h61 && c <= 8'h7A) begin
            base      = 8'h61;
            is_letter = 1'b1;
        end
        rot = 6'(c - base) + ROT;
        if (rot >= 6'd26)
            rot = rot - 6'd26;
        caesar_decrypt = is_letter ? (base + {2'b00, rot}) : c;
    endfunction

    logic rx_meta, rx_sync, rx_prev;
    logic cts_meta, cts_sync;

    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_prev  <= 1'b1;
            cts_meta <= 1'b1;
            cts_sync <= 1'b1;
        end else begin
            rx_meta  <= bus.uart_rx;
            rx_sync  <= rx_meta;
            rx_prev  <= rx_sync;
            cts_meta <= bus.uart_cts_n;
            cts_sync <= cts_meta;
        end
    end

    rx_state_t       rx_state;
    logic [CW-1:0]   rx_cnt;
    logic [2:0]      rx_bit;
    logic [7:0]      rx_shift;
    logic            rx_stop_tick;
    logic            rx_push;
    logic [7:0]      rx_byte;

    assign rx_stop_tick = (rx_state == RX_STOP) && (rx_cnt == BIT_LAST);
    assign rx_byte      = caesar_decrypt(rx_shift);

    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
        end else begin
            unique case (rx_state)
                RX_IDLE: begin
                    rx_cnt <= '0;
                    rx_bit <= '0;
                    if (rx_prev && !rx_sync)
                        rx_state <= RX_START;
                end
                RX_START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt   <= '0;
                        rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt <= '0;
                        rx_bit <= rx_bit + 1'b1;
                        if (rx_bit == 3'd7)
                            rx_state <= RX_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_state <= RX_IDLE;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk50) begin
        if (rx_state == RX_DATA && rx_cnt == BIT_LAST)
            rx_shift <= {rx_sync, rx_shift[7:1]};
    end

`ifdef UART_CAESAR_DEC_FRAME_CHECK_EN
    localparam logic [CW-1:0] STOP_PRE = CW'(BIT_CLKS - 2);
    logic frame_err_q;

    assign rx_push = rx_stop_tick && rx_sync;

    // rx_meta one cycle before the stop sample is exactly rx_sync at the stop sample,
    // so the registered pulse lands on the push cycle itself.
    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n)
            frame_err_q <= 1'b0;
        else
            frame_err_q <= (rx_state == RX_STOP) && (rx_cnt == STOP_PRE) && !rx_meta;
    end

    assign bus.frame_err = frame_err_q;
`else
    assign rx_push       = rx_stop_tick;
    assign bus.frame_err = 1'b0;
`endif

    logic [7:0]  fifo_mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        fifo_full, fifo_empty;
    logic        push_ok;
    logic        tx_pop;
    logic        overflow_q;
    tx_state_t   tx_state;

    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign tx_pop     = (tx_state == TX_IDLE) && !fifo_empty && !cts_sync;
    // A pop in the same cycle frees the slot the push lands in.
    assign push_ok    = rx_push && (!fifo_full || tx_pop);

    always_ff @(posedge clk50) begin
        if (push_ok)
            fifo_mem[wr_ptr[AW-1:0]] <= rx_byte;
    end

    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (tx_pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (rx_push && fifo_full && !tx_pop)
                overflow_q <= 1'b1;
        end
    end

    assign bus.overflow = overflow_q;

    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_bit;
    logic [7:0]    tx_shift;
    logic          tx_line;
    logic          tx_shift_en;

    assign tx_shift_en = (tx_cnt == BIT_LAST) &&
                         ((tx_state == TX_START) || (tx_state == TX_DATA && tx_bit != 3'd7));

    always_ff @(posedge clk50) begin
        if (tx_pop)
            tx_shift <= fifo_mem[rd_ptr[AW-1:0]];
        else if (tx_shift_en)
            tx_shift <= {1'b0, tx_shift[7:1]};
    end

    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_line  <= 1'b1;
        end else begin
            unique case (tx_state)
                TX_IDLE: begin
                    tx_cnt <= '0;
                    tx_bit <= '0;
                    if (tx_pop) begin
                        tx_state <= TX_START;
                        tx_line  <= 1'b0;
                    end else begin
                        tx_line  <= 1'b1;
                    end
                end
                TX_START: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        tx_state <= TX_DATA;
                        tx_line  <= tx_shift[0];
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= '0;
                        if (tx_bit == 3'd7) begin
                            tx_state <= TX_STOP;
                            tx_line  <= 1'b1;
                        end else begin
                            tx_bit  <= tx_bit + 1'b1;
                            tx_line <= tx_shift[0];
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_STOP: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        tx_state <= TX_IDLE;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                default: begin
                    tx_state <= TX_IDLE;
                    tx_line  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.uart_tx = tx_line;
endmodule

// File: tb/tb_uart_caesar_decoder.sv
// Directed bench for uart_caesar_decoder at BIT_CLKS=10, SHIFT=3, DEPTH=8.
`timescale 1ns/1ps
module tb_uart_caesar_decoder;
    localparam int BIT_CLKS = 10;

    logic clk50   = 1'b0;
    logic reset_n = 1'b0;
    uart_caesar_decoder_if bus();

    uart_caesar_decoder #(
        .CLK_FREQ (50_000_000),
        .BAUD     (5_000_000),
        .SHIFT    (3),
        .DEPTH    (8)
    ) dut (
        .clk50   (clk50),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk50 = ~clk50;

    int unsigned cyc = 0;
    always @(posedge clk50) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    logic [7:0]  rx_q[$];
    int unsigned start_q[$];
    int unsigned mon_falls = 0;
    int unsigned mon_last_fall = 0;
    int unsigned fe_count = 0;
    int unsigned fe_cyc = 0;

    // Line receiver for uart_tx: samples mid-bit, frames abandoned by reset are discarded.
    initial begin : tx_mon
        logic       prev;
        logic       busy;
        int         cnt;
        logic [7:0] data;
        int unsigned st;
        prev = 1'b1; busy = 1'b0; cnt = 0; data = '0; st = 0;
        forever begin
            @(negedge clk50);
            if (!reset_n) begin
                busy = 1'b0;
                prev = 1'b1;
            end else if (busy) begin
                cnt++;
                if (cnt == 5)
                    chk("tx_start_bit", 32'(bus.uart_tx), 32'd0);
                else if (cnt >= 15 && cnt <= 85 && (cnt - 15) % 10 == 0)
                    data[(cnt - 15) / 10] = bus.uart_tx;
                else if (cnt == 95) begin
                    chk("tx_stop_bit", 32'(bus.uart_tx), 32'd1);
                    rx_q.push_back(data);
                    start_q.push_back(st);
                end else if (cnt == 99) begin
                    busy = 1'b0;
                    prev = bus.uart_tx;
                end
            end else begin
                if (prev && !bus.uart_tx) begin
                    busy = 1'b1;
                    cnt  = 0;
                    st   = cyc;
                    mon_last_fall = cyc;
                    mon_falls++;
                end
                prev = bus.uart_tx;
            end
        end
    end

    always @(negedge clk50) begin
        if (bus.frame_err === 1'b1) begin
            fe_count <= fe_count + 1;
            fe_cyc   <= cyc;
        end
    end

    initial begin : watchdog
        #500_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk50);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            bus.uart_rx = frame[i];
            repeat (BIT_CLKS) @(negedge clk50);
        end
        bus.uart_rx = 1'b1;
    endtask

    task automatic wait_frames(input string tag, input int n, input int budget);
        int k;
        k = 0;
        while (rx_q.size() < n && k < budget) begin
            @(negedge clk50);
            k++;
        end
        chk(tag, 32'(rx_q.size()), 32'(n));
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle(2);
        reset_n = 1'b1;
        idle(3);
    endtask

    logic [7:0] map_in  [5] = '{8'h44, 8'h61, 8'h43, 8'h35, 8'h7B};
    logic [7:0] map_exp [5] = '{8'h41, 8'h78, 8'h5A, 8'h35, 8'h7B};

    initial begin : main
        int          base;
        int unsigned c0;
        int unsigned f0;
        int          k;

        bus.uart_rx    = 1'b1;
        bus.uart_cts_n = 1'b0;
        reset_n        = 1'b0;
        idle(3);
        chk("reset_tx",       32'(bus.uart_tx),   32'd1);
        chk("reset_overflow", 32'(bus.overflow),  32'd0);
        chk("reset_frame_err",32'(bus.frame_err), 32'd0);
        reset_n = 1'b1;
        idle(5);

        // Decode mapping and pipeline latency
        base = rx_q.size();
        c0   = cyc;
        for (int i = 0; i < 5; i++) begin
            send_byte(map_in[i], 1'b1);
            idle(2);
        end
        wait_frames("map_count", base + 5, 800);
        for (int i = 0; i < 5; i++)
            chk($sformatf("map_data%0d", i), 32'(rx_q[base + i]), 32'(map_exp[i]));
        chk("map_first_start", start_q[base] - c0, 32'd99);

        // Flow control and overflow
        do_reset();
        bus.uart_cts_n = 1'b1;
        idle(5);
        base = rx_q.size();
        for (int i = 0; i < 9; i++) begin
            send_byte(8'(8'h44 + i), 1'b1);
            idle(2);
            if (i == 7)
                chk("ovf_after_8", 32'(bus.overflow), 32'd0);
        end
        chk("ovf_after_9", 32'(bus.overflow), 32'd1);
        chk("cts_hold_no_tx", 32'(rx_q.size()), 32'(base));
        chk("cts_hold_line", 32'(bus.uart_tx), 32'd1);
        bus.uart_cts_n = 1'b0;
        wait_frames("flow_count", base + 8, 1000);
        idle(300);
        chk("flow_exact_8", 32'(rx_q.size()), 32'(base + 8));
        for (int i = 0; i < 8; i++)
            chk($sformatf("flow_data%0d", i), 32'(rx_q[base + i]), 32'(8'h41 + i));
        for (int i = 1; i < 8; i++)
            chk($sformatf("flow_gap%0d", i), start_q[base + i] - start_q[base + i - 1], 32'd101);
        chk("ovf_sticky", 32'(bus.overflow), 32'd1);

        // Frame error (low stop bit)
        do_reset();
        base = rx_q.size();
        f0   = fe_count;
        c0   = cyc;
        send_byte(8'h44, 1'b0);
        idle(250);
`ifdef UART_CAESAR_DEC_FRAME_CHECK_EN
        chk("ferr_pulses", fe_count - f0, 32'd1);
        chk("ferr_cycle",  fe_cyc - c0,   32'd97);
        chk("ferr_no_tx",  32'(rx_q.size()), 32'(base));
`else
        chk("ferr_pulses", fe_count - f0, 32'd0);
        chk("ferr_tx_count", 32'(rx_q.size()), 32'(base + 1));
        chk("ferr_tx_data",  32'(rx_q[base]), 32'h41);
`endif
        chk("ferr_no_overflow", 32'(bus.overflow), 32'd0);

        // Glitch rejection
        base = rx_q.size();
        f0   = fe_count;
        bus.uart_rx = 1'b0;
        idle(3);
        bus.uart_rx = 1'b1;
        idle(150);
        chk("glitch_no_tx",   32'(rx_q.size()), 32'(base));
        chk("glitch_no_ferr", fe_count - f0, 32'd0);
        send_byte(8'h44, 1'b1);
        wait_frames("glitch_next_count", base + 1, 300);
        chk("glitch_next_data", 32'(rx_q[base]), 32'h41);

        // Reset during TX data bit 3, with a second byte still queued
        do_reset();
        bus.uart_cts_n = 1'b1;
        send_byte(8'h44, 1'b1);
        idle(2);
        send_byte(8'h45, 1'b1);
        idle(2);
        base = rx_q.size();
        f0   = mon_falls;
        bus.uart_cts_n = 1'b0;
        k = 0;
        while (mon_falls == f0 && k < 100) begin
            @(negedge clk50);
            k++;
        end
        chk("rst_mid_start_seen", mon_falls - f0, 32'd1);
        k = 0;
        while (cyc != mon_last_fall + 45 && k < 100) begin
            @(negedge clk50);
            k++;
        end
        chk("rst_mid_pre_tx", 32'(bus.uart_tx), 32'd0);
        #1 reset_n = 1'b0;
        #1;
        chk("rst_mid_tx",        32'(bus.uart_tx),   32'd1);
        chk("rst_mid_overflow",  32'(bus.overflow),  32'd0);
        chk("rst_mid_frame_err", 32'(bus.frame_err), 32'd0);
        idle(2);
        reset_n = 1'b1;
        idle(300);
        chk("rst_mid_fifo_empty", 32'(rx_q.size()), 32'(base));
        chk("rst_mid_tx_idle",    32'(bus.uart_tx), 32'd1);

        // Push at full coinciding with the first pop
        do_reset();
        bus.uart_cts_n = 1'b1;
        idle(5);
        base = rx_q.size();
        for (int i = 0; i < 8; i++) begin
            send_byte(8'(8'h44 + i), 1'b1);
            idle(2);
        end
        chk("full_no_overflow", 32'(bus.overflow), 32'd0);
        c0 = cyc;
        fork
            send_byte(8'h4C, 1'b1);
            begin
                repeat (95) @(negedge clk50);
                bus.uart_cts_n = 1'b0;
            end
        join
        idle(2);
        chk("pushpop_no_overflow", 32'(bus.overflow), 32'd0);
        wait_frames("pushpop_count", base + 9, 1200);
        for (int i = 0; i < 9; i++)
            chk($sformatf("pushpop_data%0d", i), 32'(rx_q[base + i]), 32'(8'h41 + i));
        chk("pushpop_first_start", start_q[base] - c0, 32'd98);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_caesar_decoder.md
# uart_caesar_decoder

Receive-side counterpart of the Caesar UART echo. It accepts Caesar-encrypted bytes on a UART RX line (8N1), decrypts them by rotating letters back by `SHIFT`, and buffers the plaintext in a small FIFO. It then retransmits the plaintext on a UART TX line, gated by an active-low clear-to-send input. The block is self-contained, with its own RX, FIFO and TX, and sits at the board top level next to the encrypting echo block.

## Interface
- `CLK_FREQ`, 50_000_000: clock frequency in Hz.
- `BAUD`, 115_200: line rate. `BIT_CLKS = CLK_FREQ / BAUD` (integer division, must be ≥ 4).
- `SHIFT`, 3: decryption rotation, legal range 0..25.
- `DEPTH`, 8: FIFO depth in bytes, power of two, ≥ 2.
- `clk50` in, 1: system clock.
- `reset_n` in, 1: reset. One clock; reset is asynchronous and active-low.
- `uart_rx` in, 1: ciphertext serial input, idle high, asynchronous.
- `uart_cts_n` in, 1: clear-to-send, active-low, asynchronous.
- `uart_tx` out, 1: plaintext serial output, idle high.
- `overflow` out, 1: sticky flag, set when a received byte is dropped because the FIFO is full.
- `frame_err` out, 1: one-cycle pulse when a received frame is rejected.

## Operation
- **Input synchronisation:** `uart_rx` and `uart_cts_n` each pass through a 2-FF synchroniser. All logic uses the synchronised copies.
- **RX FSM states:** IDLE, START, DATA, STOP.
  - IDLE → START on a synchronised high→low edge.
  - In START, wait `BIT_CLKS/2` cycles and sample. If the line is low, go to DATA. If high, the event is a glitch: go back to IDLE with no output.
  - In DATA, sample 8 bits LSB-first, one every `BIT_CLKS` cycles.
  - In STOP, sample once `BIT_CLKS` after the last data bit, then return to IDLE. The stop-sample cycle is the push cycle P.
- **Decryption (applied before push):**
  - 0x41–0x5A maps to `((c-0x41-SHIFT) mod 26)+0x41`.
  - 0x61–0x7A maps to `((c-0x61-SHIFT) mod 26)+0x61`.
  - All other codes pass through unchanged.
  - Arithmetic is done in 6-bit unsigned by adding `26-SHIFT` and conditionally subtracting 26.
- **FIFO:**
  - Circular buffer with read/write pointers one bit wider than `log2(DEPTH)`. Full when the MSBs differ and the remaining bits are equal; empty when the pointers are equal.
  - A push while full drops the byte and sets `overflow`. `overflow` clears only on reset.
  - Push and pop in the same cycle are both performed, including when the FIFO is full; in that case no overflow is raised.
- **TX FSM states:** IDLE, START, DATA, STOP. Each bit lasts `BIT_CLKS` cycles.
  - IDLE pops when the FIFO is not empty and synchronised `cts_n` is 0, then goes to START.
  - `cts_n` is checked only in IDLE. A frame that has started always completes.
  - After STOP, return to IDLE for at least one cycle.

## Timing
- Reset values:
  - `uart_tx` = 1, `overflow` = 0, `frame_err` = 0.
  - FIFO empty; both FSMs in IDLE.
  - Synchroniser flops reset to 1.
- Reset asserted mid-frame: every output takes its reset value immediately (asynchronously), and any partial RX or TX frame is discarded.
- Latency: the byte is pushed at P. If TX is idle and CTS is low, the pop happens at P+1 and `uart_tx` falls at P+2.
- TX frame length is `10*BIT_CLKS` cycles. Back-to-back frames start `10*BIT_CLKS+1` cycles apart.
- `frame_err` is high for exactly the cycle P.
- RX input-to-sample delay is 2 cycles (the synchroniser). Maximum tolerated baud mismatch is about ±4 %.

## Configuration
- `UART_CAESAR_DEC_FRAME_CHECK_EN` defined: a frame whose stop-bit sample is low is not pushed, and `frame_err` pulses at P.
- `UART_CAESAR_DEC_FRAME_CHECK_EN` undefined: the stop bit is ignored, every frame is pushed, and `frame_err` is tied to 0.

## Test plan
All scenarios use `CLK_FREQ=50_000_000`, `BAUD=5_000_000` (`BIT_CLKS=10`), `SHIFT=3`, `DEPTH=8`, macro defined, and `uart_cts_n=0` unless stated otherwise.
- **Decode mapping:** send 0x44, 0x61, 0x43, 0x35, 0x7B → TX emits 0x41, 0x78, 0x5A, 0x35, 0x7B in order, each frame 100 cycles with start 0 and stop 1. The first start bit appears at P+2.
- **Flow control and overflow:** hold `uart_cts_n=1` and send 9 bytes 0x44..0x4C. `overflow` rises at the 9th stop sample and `uart_tx` stays 1. Release CTS → exactly 8 bytes 0x41..0x48 are emitted, spaced 101 cycles.
- **Frame error:** send 0x44 with a low stop bit → `frame_err` is high for 1 cycle, nothing is transmitted, and `overflow` stays 0. Repeat with the macro undefined → 0x41 is transmitted and `frame_err` stays 0.
- **Glitch rejection:** drive `uart_rx` low for 3 cycles → no RX activity, no output. A following valid 0x44 → 0x41.
- **Reset mid-frame:** pull `reset_n` low during TX data bit 3 → `uart_tx`=1 within the same cycle. After release, TX stays idle and the FIFO is empty.
- **Simultaneous push/pop at full:** fill the FIFO to 8 with CTS high, then release CTS so the first pop coincides with a 9th push → no overflow, and 9 bytes come out in order.
